// File: rtl/bus_test_sequencer.sv
// Bus test sequencer: walks every CAN bus through an RX campaign, a fixed idle
// gap, a TX campaign and an optional custom-message phase, with a per-bus
// watchdog that records the bus that last failed to answer.
// Optional feature: define SEQ_ADV_TEST_EN to enable the ADV (custom message)
// phase; when undefined adv_req/costum_msg_end are ignored and ADV is unreachable.
module bus_test_sequencer #(
  parameter int unsigned N_BUSES        = 32,
  parameter int unsigned GAP_CYCLES     = 120,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned BUS_W         = (N_BUSES > 1) ? $clog2(N_BUSES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sign_on,
  input  logic [BUS_W-1:0] n_buses,
  input  logic             test_rx_end,
  input  logic             test_tx_end,
  input  logic             costum_msg_end,
  input  logic             adv_req,
  output logic             test_rx,
  output logic             test_tx,
  output logic             test_advanced,
  output logic             endwait_all,
  output logic [BUS_W-1:0] bus_sel,
  output logic [3:0]       phase,
  output logic             done,
  output logic             timeout_err,
  output logic [BUS_W-1:0] err_bus
);

`ifdef SEQ_ADV_TEST_EN
  localparam bit ADV_EN = 1'b1;
`else
  localparam bit ADV_EN = 1'b0;
`endif

  localparam int unsigned WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_W    = (WD_BITS > 16) ? WD_BITS : 16;
  localparam int unsigned GAP_BITS = $clog2(GAP_CYCLES + 1);
  localparam int unsigned GAP_W   = (GAP_BITS > 1) ? GAP_BITS : 1;

  localparam logic [BUS_W-1:0] LAST_BUS = BUS_W'(N_BUSES - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RX_RUN  = 4'd1,
    RX_NEXT = 4'd2,
    ENDWAIT = 4'd3,
    GAP     = 4'd4,
    TX_RUN  = 4'd5,
    TX_NEXT = 4'd6,
    ADV     = 4'd7,
    DONE    = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [BUS_W-1:0] bus_d, last_q, last_d, ebus_d;
  logic             adv_q, adv_d, terr_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             expire, in_run;

  assign phase = state_q;

  // State, campaign context and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bus_sel       <= '0;
      last_q        <= '0;
      adv_q         <= 1'b0;
      wd_q          <= '0;
      gap_q         <= '0;
      timeout_err   <= 1'b0;
      err_bus       <= '0;
      test_rx       <= 1'b0;
      test_tx       <= 1'b0;
      test_advanced <= 1'b0;
      endwait_all   <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_sel       <= bus_d;
      last_q        <= last_d;
      adv_q         <= adv_d;
      wd_q          <= wd_d;
      gap_q         <= gap_d;
      timeout_err   <= terr_d;
      err_bus       <= ebus_d;
      test_rx       <= (state_d == RX_RUN);
      test_tx       <= (state_d == TX_RUN);
      test_advanced <= ADV_EN && (state_d == ADV);
      endwait_all   <= (state_d == ENDWAIT);
      done          <= (state_d == DONE);
    end
  end

  // Next-state, bus walk, gap and watchdog logic
  always_comb begin
    state_d = state_q;
    bus_d   = bus_sel;
    last_d  = last_q;
    adv_d   = adv_q;
    gap_d   = '0;
    terr_d  = timeout_err;
    ebus_d  = err_bus;
    expire  = (wd_q == WD_LIMIT);
    in_run  = (state_q == RX_RUN) || (state_q == TX_RUN) || (state_q == ADV);

    case (state_q)
      IDLE: begin
        if (sign_on) begin
          last_d  = (n_buses > LAST_BUS) ? LAST_BUS : n_buses;
          adv_d   = ADV_EN && adv_req;
          bus_d   = '0;
          state_d = RX_RUN;
        end
      end
      RX_RUN: begin
        // An end pulse in the expiry cycle wins over the watchdog
        if (test_rx_end) begin
          state_d = RX_NEXT;
        end else if (expire) begin
          terr_d  = 1'b1;
          ebus_d  = bus_sel;
          state_d = RX_NEXT;
        end
      end
      RX_NEXT: begin
        if (bus_sel < last_q) begin
          bus_d   = bus_sel + BUS_W'(1);
          state_d = RX_RUN;
        end else begin
          bus_d   = '0;
          state_d = ENDWAIT;
        end
      end
      ENDWAIT: state_d = GAP;
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = TX_RUN;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      TX_RUN: begin
        if (test_tx_end) begin
          state_d = TX_NEXT;
        end else if (expire) begin
          terr_d  = 1'b1;
          ebus_d  = bus_sel;
          state_d = TX_NEXT;
        end
      end
      TX_NEXT: begin
        if (bus_sel < last_q) begin
          bus_d   = bus_sel + BUS_W'(1);
          state_d = TX_RUN;
        end else if (ADV_EN && adv_q) begin
          state_d = ADV;
        end else begin
          bus_d   = '0;
          state_d = DONE;
        end
      end
      ADV: begin
        if (ADV_EN && costum_msg_end) begin
          state_d = DONE;
        end else if (expire) begin
          terr_d  = 1'b1;
          ebus_d  = bus_sel;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!sign_on) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog counts residency in a request state and restarts on any transition
    wd_d = (in_run && (state_d == state_q)) ? wd_q + WD_W'(1) : '0;
  end

endmodule

// File: tb/tb_bus_test_sequencer.sv
// Scoreboard bench for bus_test_sequencer: a campaign planner pushes the
// expected request/gap/done events into a queue, a responder answers requests
// after chosen delays, and a monitor pops and compares observed events.
module tb_bus_test_sequencer;
  localparam int unsigned NB  = 32;
  localparam int unsigned GAP = 120;
  localparam int unsigned TO  = 50;
  localparam int K_RX = 0, K_TX = 1, K_ADV = 2, K_EW = 3, K_DONE = 4;
`ifdef SEQ_ADV_TEST_EN
  localparam bit ADV_ON = 1'b1;
`else
  localparam bit ADV_ON = 1'b0;
`endif

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sign_on = 1'b0;
  logic [4:0] n_buses = '0;
  logic       test_rx_end = 1'b0, test_tx_end = 1'b0, costum_msg_end = 1'b0;
  logic       adv_req = 1'b0;
  logic       test_rx, test_tx, test_advanced, endwait_all, done, timeout_err;
  logic [4:0] bus_sel, err_bus;
  logic [3:0] phase;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  rx_d[32];
  int  tx_d[32];
  int  adv_d = 1;
  int  exp_terr = 0;
  int  exp_ebus = 0;

  bus_test_sequencer #(.N_BUSES(NB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .sign_on(sign_on), .n_buses(n_buses),
    .test_rx_end(test_rx_end), .test_tx_end(test_tx_end),
    .costum_msg_end(costum_msg_end), .adv_req(adv_req),
    .test_rx(test_rx), .test_tx(test_tx), .test_advanced(test_advanced),
    .endwait_all(endwait_all), .bus_sel(bus_sel), .phase(phase),
    .done(done), .timeout_err(timeout_err), .err_bus(err_bus)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic got_event(int kind, int a, int b);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d a %0d b %0d expected none", kind, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b) begin
        errors++;
        $display("FAIL event: got kind %0d a %0d b %0d expected kind %0d a %0d b %0d",
                 kind, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // A request answered after d cycles stays high min(d, TO) cycles; d > TO is a timeout
  task automatic push_req(int kind, int bus, int d);
    ev_t e;
    e = '{kind, bus, (d > TO) ? TO : d};
    exp_q.push_back(e);
    if (d > TO) begin
      exp_terr = 1;
      exp_ebus = bus;
    end
  endtask

  task automatic plan(int last, bit adv);
    ev_t e;
    for (int b = 0; b <= last; b++) push_req(K_RX, b, rx_d[b]);
    e = '{K_EW, GAP, 0};
    exp_q.push_back(e);
    for (int b = 0; b <= last; b++) push_req(K_TX, b, tx_d[b]);
    if (ADV_ON && adv) push_req(K_ADV, last, adv_d);
    e = '{K_DONE, exp_terr, exp_ebus};
    exp_q.push_back(e);
  endtask

  function automatic int pick_delay(bit allow_to);
    int r;
    r = int'($urandom_range(0, 9));
    if (allow_to && r == 0) return int'(TO);
    if (allow_to && r == 1) return int'(TO) + 5;
    return int'($urandom_range(1, 15));
  endfunction

  task automatic fill(int d_rx, int d_tx, int d_adv);
    for (int b = 0; b < 32; b++) begin
      rx_d[b] = d_rx;
      tx_d[b] = d_tx;
    end
    adv_d = d_adv;
  endtask

  task automatic fill_random(bit allow_to);
    for (int b = 0; b < 32; b++) begin
      rx_d[b] = pick_delay(allow_to);
      tx_d[b] = pick_delay(allow_to);
    end
    adv_d = pick_delay(allow_to);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      n_buses = 5'($urandom);
      adv_req = 1'($urandom);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_reached", int'(seen), 1);
  endtask

  task automatic run_campaign(int nb, bit adv);
    int last;
    last = (nb > int'(NB) - 1) ? int'(NB) - 1 : nb;
    plan(last, adv);
    @(posedge clk); #1;
    sign_on = 1'b1;
    n_buses = 5'(nb);
    adv_req = adv;
    wait_done();
    repeat (2) begin @(posedge clk); #1; end
    check("done_hold", int'(done), 1);
    check("phase_done", int'(phase), 8);
    sign_on = 1'b0;
    @(posedge clk); #1;
    check("phase_idle", int'(phase), 0);
    check("done_clear", int'(done), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_reqs"}, int'(test_rx) + int'(test_tx) + int'(test_advanced), 0);
    check({tag, "_endwait"}, int'(endwait_all), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_bus_sel"}, int'(bus_sel), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
    check({tag, "_err_bus"}, int'(err_bus), 0);
  endtask

  // Responder: answers each request after its planned delay, plus stray pulses
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (test_rx || test_tx || test_advanced) cnt++;
      else cnt = 0;
      test_rx_end    = test_rx ? (cnt == rx_d[bus_sel]) : ($urandom_range(0, 7) == 0);
      test_tx_end    = test_tx ? (cnt == tx_d[bus_sel]) : ($urandom_range(0, 7) == 0);
      costum_msg_end = test_advanced ? (cnt == adv_d) : ($urandom_range(0, 7) == 0);
    end
  end

  // Monitor: turns DUT activity into events and checks them against the queue
  initial begin
    bit p_rx = 0, p_tx = 0, p_adv = 0, p_done = 0, in_gap = 0;
    int len = 0, cur_bus = 0, gcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_rx = 0; p_tx = 0; p_adv = 0; p_done = 0; in_gap = 0;
        len = 0; gcnt = 0;
      end else begin
        check("one_request", int'((int'(test_rx) + int'(test_tx) + int'(test_advanced)) <= 1), 1);
        if (test_rx || test_tx || test_advanced) begin
          if (!(p_rx || p_tx || p_adv)) begin
            cur_bus = int'(bus_sel);
            len = 0;
          end
          len++;
        end
        if (p_rx && !test_rx) got_event(K_RX, cur_bus, len);
        if (p_tx && !test_tx) got_event(K_TX, cur_bus, len);
        if (p_adv && !test_advanced) got_event(K_ADV, cur_bus, len);
        if (endwait_all) begin
          in_gap = 1;
          gcnt = 0;
        end else if (in_gap) begin
          if (test_tx) begin
            got_event(K_EW, gcnt, 0);
            in_gap = 0;
          end else if (!test_rx && !test_advanced) begin
            gcnt++;
          end
        end
        if (done && !p_done) got_event(K_DONE, int'(timeout_err), int'(err_bus));
        p_rx = test_rx; p_tx = test_tx; p_adv = test_advanced; p_done = done;
      end
    end
  end

  // Stimulus
  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    fill(10, 10, 10);
    run_campaign(3, 1'b0);

    fill(3, 4, 5);
    rx_d[0] = int'(TO);
    run_campaign(0, 1'b0);

    fill(4, 6, 5);
    rx_d[0] = 5;
    rx_d[1] = int'(TO) + 10;
    run_campaign(1, 1'b0);

    // Reset during TX of bus 2 aborts the campaign
    fill(10, 10, 10);
    plan(3, 1'b0);
    @(posedge clk); #1;
    sign_on = 1'b1;
    n_buses = 5'd3;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (test_tx && bus_sel == 5'd2) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_tx_bus2", int'(seen), 1);
    rst = 1'b1;
    exp_q.delete();
    exp_terr = 0;
    exp_ebus = 0;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    sign_on = 1'b0;

    fill(2, 3, 7);
    run_campaign(2, 1'b1);

    fill(2, 2, 2);
    run_campaign(31, 1'b0);

    fill(5, 5, int'(TO) + 3);
    run_campaign(1, 1'b1);

    for (int c = 0; c < 6; c++) begin
      fill_random(1'b1);
      run_campaign(int'($urandom_range(0, 6)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
